pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register for the sMIPS core. It is the generic successor of the fixed per-stage latches: a valid/ready handshake replaces the global stall vector, and the payload width is a parameter. It can optionally hold a skid entry so that upstream `in_ready` never depends combinationally on downstream `out_ready`. It inserts a programmable bubble (NOP payload) whenever it holds no valid instruction, supports synchronous flush, and counts downstream back-pressure cycles. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB); one instance per boundary.

## Interface
Parameters:
- `DATA_W`, 128: payload width in bits (aluop, alusel, operands, wreg, link address, delay-slot flags, inst, concatenated by the instantiating stage).
- `BUBBLE`, {DATA_W{1'b0}}: payload driven whenever `out_valid`=0. Must decode downstream as NOP with write disabled.
- `SKID`, 1: 1 = two-entry (main + skid), registered `in_ready`; 0 = single entry, combinational `in_ready`.
- `CNT_W`, 16: back-pressure counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries (branch mispredict or exception).
- `in_valid`  in  1  upstream presents a payload.
- `in_ready`  out  1  this stage accepts the payload this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  the main entry holds a valid payload.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  main entry payload; `BUBBLE` when `out_valid`=0.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Handshake rules:
  - Input transfer: `in_valid`&&`in_ready`.
  - Output transfer: `out_valid`&&`out_ready`.
  - A payload is never duplicated or dropped, except on flush.
- State is {main_v, main_d, skid_v, skid_d}. Valid states: EMPTY (0,0), FULL (1,0), SKIDDED (1,1). skid_v=1 with main_v=0 is illegal.
- SKID=1:
  - `in_ready` = !skid_v, registered.
  - EMPTY + input transfer -> FULL.
  - FULL + output transfer + input transfer -> FULL, main loaded with the new payload.
  - FULL + output transfer, no input -> EMPTY.
  - FULL + no output transfer + input transfer -> SKIDDED, input stored in skid.
  - SKIDDED + output transfer -> FULL, main <= skid. No input is accepted, since `in_ready`=0.
- SKID=0:
  - `in_ready` = !main_v || `out_ready`.
  - Only the EMPTY and FULL states exist.
- `out_data` = main_v ? main_d : `BUBBLE`. The payload register is also loaded with `BUBBLE` whenever main_v clears, so there is no stale data for waveform or debug.
- `flush`:
  - Next state is EMPTY with `BUBBLE` payloads, whatever the handshake activity.
  - An input transfer in the flush cycle is discarded, and the upstream sees it as accepted.
  - An output transfer in the flush cycle still counts as taken by downstream.
  - Flush has priority over every other update.
- `stall_cnt`:
  - Increments by 1 in each cycle where `out_valid`&&!`out_ready`.
  - Saturates at 2^CNT_W-1.
  - `cnt_clr` clears it to 0 and has priority over the increment.
  - Unaffected by `flush`.

## Timing
- Reset (`rst`=0, asynchronous): main_v=0, skid_v=0, both payloads=`BUBBLE`, `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `stall_cnt`=0. All outputs hold these values from reset assertion until the first rising edge after deassertion.
- Reset asserted mid-operation discards held payloads immediately; no partial transfer completes.
- Latency: 1 cycle. A payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 payload per cycle while `out_ready`=1, in both SKID modes.
- SKID=1: `in_ready` falls one cycle after the first back-pressured input is absorbed. It rises the cycle after the skid drains.
- SKID=0: `in_ready` follows `out_ready` combinationally when FULL.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst`=0 mid-stream with main=0x11, skid=0x22, then release.
  - Required: `out_valid`=0, `out_data`=`BUBBLE` immediately; `in_ready`=1; `stall_cnt`=0; the first payload after release, 0xA5, appears one cycle after it is accepted.
- Streaming (SKID=1):
  - Stimulus: payloads 1..8 on consecutive cycles with `out_ready`=1.
  - Required: `out_data` shows 1..8 on consecutive cycles, one cycle delayed; `in_ready` stays 1; `stall_cnt`=0.
- Back-pressure/skid:
  - Stimulus: `out_ready`=0 for 3 cycles while sending 1,2,3.
  - Required: 1 held in main, 2 captured in skid, `in_ready`=0 from the next cycle, 3 held upstream.
  - Then `out_ready`=1: output sequence is 1,2,3 with none lost or duplicated; `stall_cnt`=3.
- Flush priority:
  - Stimulus: in SKIDDED state (main=5, skid=6), assert `flush` together with `in_valid` carrying 7.
  - Required: next cycle `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1; 7 never appears at the output.
- SKID=0 mode:
  - Stimulus: `out_ready` toggling 1,0,1,0 with continuous input.
  - Required: `in_ready` mirrors `out_ready` while FULL; order is preserved; no state beyond one entry.
- Counter:
  - Stimulus: CNT_W=4, hold `out_valid`=1 with `out_ready`=0 for 20 cycles.
  - Required: `stall_cnt` saturates at 15; `cnt_clr` together with an active stall gives 0 on the next cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with optional skid entry, bubble insertion and stall counter
module pipe_stage_buf #(
  parameter int DATA_W = 128,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter bit SKID = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic in_xfer, out_xfer;
  // with a skid entry, in_ready comes straight from a flop and never sees out_ready
  assign in_ready = SKID ? !skid_v : (!main_v || out_ready);
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data = main_v ? main_d : BUBBLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v <= 1'b0;
      main_d <= BUBBLE;
      skid_v <= 1'b0;
      skid_d <= BUBBLE;
    end else if (flush) begin
      main_v <= 1'b0;
      main_d <= BUBBLE;
      skid_v <= 1'b0;
      skid_d <= BUBBLE;
    end else if (skid_v) begin
      if (out_xfer) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
        skid_d <= BUBBLE;
      end
    end else if (main_v && !out_xfer) begin
      if (in_xfer) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end else if (in_xfer) begin
      main_v <= 1'b1;
      main_d <= in_data;
    end else if (main_v) begin
      main_v <= 1'b0;
      main_d <= BUBBLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else stall_cnt <= cnt_clr ? '0 : (main_v && !out_ready && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf in skid, no-skid and narrow-counter configurations
module tb_pipe_stage_buf;
  localparam logic [7:0] BUB = 8'hEE;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic ir1, ov1, ir0, ov0, ir4, ov4;
  logic [7:0] od1, od0, od4;
  logic [15:0] sc1, sc0;
  logic [3:0] sc4;
  int checks = 0, errors = 0;
  int acc;
  always #5 clk = ~clk;
  pipe_stage_buf #(.DATA_W(8), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .cnt_clr(cnt_clr), .stall_cnt(sc1));
  pipe_stage_buf #(.DATA_W(8), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .cnt_clr(cnt_clr), .stall_cnt(sc0));
  pipe_stage_buf #(.DATA_W(8), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .cnt_clr(cnt_clr), .stall_cnt(sc4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_ov", ov1, 0);
    chk("rst_od", od1, BUB);
    chk("rst_ir", ir1, 1);
    chk("rst_sc", sc1, 0);
    rst = 1'b1;
    // fill main with 0x11 and skid with 0x22, then reset mid-stream
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    cyc();
    in_data = 8'h22;
    cyc();
    chk("pre_od", od1, 8'h11);
    chk("pre_ir", ir1, 0);
    rst = 1'b0;
    #1;
    chk("mid_ov", ov1, 0);
    chk("mid_od", od1, BUB);
    chk("mid_ir", ir1, 1);
    chk("mid_sc", sc1, 0);
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    chk("a5_ir", ir1, 1);
    cyc();
    chk("a5_ov", ov1, 1);
    chk("a5_od", od1, 8'hA5);
    in_valid = 1'b0;
    cyc();
    chk("a5_drain_ov", ov1, 0);
    chk("a5_drain_od", od1, BUB);
    // streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      chk("str_ir", ir1, 1);
      cyc();
      chk("str_ov", ov1, 1);
      chk("str_od", od1, i);
    end
    in_valid = 1'b0;
    cyc();
    chk("str_end_ov", ov1, 0);
    chk("str_sc", sc1, 0);
    // back-pressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    cyc();
    chk("bp1_od", od1, 8'h01);
    chk("bp1_ir", ir1, 1);
    in_data = 8'h02;
    cyc();
    chk("bp2_od", od1, 8'h01);
    chk("bp2_ir", ir1, 0);
    in_data = 8'h03;
    cyc();
    chk("bp3_od", od1, 8'h01);
    chk("bp3_ir", ir1, 0);
    cyc();
    chk("bp4_od", od1, 8'h01);
    chk("bp4_sc", sc1, 3);
    out_ready = 1'b1;
    cyc();
    chk("bp5_od", od1, 8'h02);
    chk("bp5_ir", ir1, 1);
    cyc();
    chk("bp6_od", od1, 8'h03);
    in_valid = 1'b0;
    cyc();
    chk("bp7_ov", ov1, 0);
    chk("bp_sc", sc1, 3);
    // flush while SKIDDED, with 7 offered upstream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    cyc();
    in_data = 8'h06;
    cyc();
    chk("fl_pre_od", od1, 8'h05);
    chk("fl_pre_ir", ir1, 0);
    flush = 1'b1; in_data = 8'h07;
    cyc();
    chk("fl_ov", ov1, 0);
    chk("fl_od", od1, BUB);
    chk("fl_ir", ir1, 1);
    chk("fl_sc", sc1, 5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("fl_post_ov", ov1, 0);
    chk("fl_post_od", od1, BUB);
    // accepted input in a flush cycle is discarded
    in_valid = 1'b1; in_data = 8'h08; flush = 1'b1;
    cyc();
    chk("fl_acc_ov", ov1, 0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl_acc_od", od1, BUB);
    // no-skid mode with toggling out_ready
    rst = 1'b0;
    #1;
    rst = 1'b1;
    acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      out_ready = (k % 2 == 0);
      in_data = 8'(8'h10 + acc);
      #1;
      chk("s0_ir", ir0, out_ready);
      cyc();
      if (out_ready) acc++;
      chk("s0_od", od0, 8'h10 + acc - 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("s0_end_ov", ov0, 0);
    chk("s0_end_od", od0, BUB);
    // narrow counter saturation and clear
    rst = 1'b0;
    #1;
    rst = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    cyc();
    in_valid = 1'b0;
    repeat (14) cyc();
    chk("c4_14", sc4, 14);
    repeat (6) cyc();
    chk("c4_sat", sc4, 15);
    chk("c4_ov", ov4, 1);
    cnt_clr = 1'b1;
    cyc();
    chk("c4_clr", sc4, 0);
    cnt_clr = 1'b0;
    cyc();
    chk("c4_inc", sc4, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
